single_exp_sched: RTL and testbench

SINGLE_EXP_SCHED -- requirements
Module: single_exp_sched

---
 rtl/single_exp_sched.sv | 139 +++++++++++++
 tb/tb_single_exp_sched.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/single_exp_sched.sv
// rtl/single_exp_sched.sv - round-robin front end sharing one single_exp unit among NREQ requesters
module single_exp_sched #(
  parameter int NREQ         = 4,
  parameter int MAX_INFLIGHT = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [32*NREQ-1:0]            req_a,
  output logic [NREQ-1:0]               req_ready,
  output logic                          exp_in_valid,
  output logic [31:0]                   exp_a,
  input  logic                          exp_out_valid,
  input  logic [31:0]                   exp_c,
  output logic [NREQ-1:0]               rsp_valid,
  output logic [31:0]                   rsp_c,
  output logic [$clog2(MAX_INFLIGHT):0] inflight,
  output logic                          err_orphan
);

  localparam int IW = $clog2(NREQ);
  localparam int PW = $clog2(MAX_INFLIGHT);
  localparam int CW = PW + 1;

  logic [IW-1:0]   last_grant_q, last_grant_d;
  logic            exp_in_valid_q, exp_in_valid_d;
  logic [31:0]     exp_a_q, exp_a_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_c_q, rsp_c_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic            err_orphan_q, err_orphan_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [IW-1:0]   tag_mem_q [MAX_INFLIGHT];
  logic [IW-1:0]   tag_mem_d [MAX_INFLIGHT];

  logic            grant_found;
  logic [IW-1:0]   grant_idx;
  logic [IW-1:0]   scan_idx;
  logic            slot_free;
  logic            push;
  logic            pop;
  logic            empty;
  logic            orphan;
  logic [IW-1:0]   pop_tag;

  // Round-robin search starting one past the last granted requester
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      scan_idx = IW'((int'(last_grant_q) + k) % NREQ);
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // Handshake and tag-queue control; a same-cycle pop frees a slot when full,
  // and a pop on an empty queue consumes the tag being pushed that cycle
  always_comb begin
    empty     = (inflight_q == '0);
    slot_free = (inflight_q != CW'(MAX_INFLIGHT)) || exp_out_valid;
    push      = grant_found && slot_free && !rstn;
    req_ready = push ? (NREQ'(1) << grant_idx) : '0;
    pop       = exp_out_valid && (!empty || push);
    orphan    = exp_out_valid && empty && !push;
    pop_tag   = empty ? grant_idx : tag_mem_q[rd_ptr_q];
  end

  // Next-state computation for issue, return, tag queue and error flag
  always_comb begin
    last_grant_d   = last_grant_q;
    exp_in_valid_d = push;
    exp_a_d        = exp_a_q;
    rsp_valid_d    = '0;
    rsp_c_d        = rsp_c_q;
    inflight_d     = inflight_q;
    err_orphan_d   = err_orphan_q || orphan;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    tag_mem_d      = tag_mem_q;
    if (push) begin
      last_grant_d          = grant_idx;
      exp_a_d               = req_a[32*grant_idx +: 32];
      tag_mem_d[wr_ptr_q]   = grant_idx;
      wr_ptr_d              = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rsp_valid_d = NREQ'(1) << pop_tag;
      rsp_c_d     = exp_c;
      rd_ptr_d    = rd_ptr_q + PW'(1);
    end
    if (push && !pop) begin
      inflight_d = inflight_q + CW'(1);
    end else if (pop && !push) begin
      inflight_d = inflight_q - CW'(1);
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rstn) begin
      last_grant_q   <= IW'(NREQ - 1);
      exp_in_valid_q <= 1'b0;
      exp_a_q        <= '0;
      rsp_valid_q    <= '0;
      rsp_c_q        <= '0;
      inflight_q     <= '0;
      err_orphan_q   <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      for (int i = 0; i < MAX_INFLIGHT; i++) begin
        tag_mem_q[i] <= '0;
      end
    end else begin
      last_grant_q   <= last_grant_d;
      exp_in_valid_q <= exp_in_valid_d;
      exp_a_q        <= exp_a_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_c_q        <= rsp_c_d;
      inflight_q     <= inflight_d;
      err_orphan_q   <= err_orphan_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      tag_mem_q      <= tag_mem_d;
    end
  end

  assign exp_in_valid = exp_in_valid_q;
  assign exp_a        = exp_a_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_c        = rsp_c_q;
  assign inflight     = inflight_q;
  assign err_orphan   = err_orphan_q;

endmodule

// File: tb/tb_single_exp_sched.sv
// tb/tb_single_exp_sched.sv - directed self-checking bench for single_exp_sched
module tb_single_exp_sched;

  logic         clk = 1'b0;
  logic         rstn;
  logic [3:0]   req_valid;
  logic [127:0] req_a;
  logic [3:0]   req_ready;
  logic         exp_in_valid;
  logic [31:0]  exp_a;
  logic         exp_out_valid;
  logic [31:0]  exp_c;
  logic [3:0]   rsp_valid;
  logic [31:0]  rsp_c;
  logic [4:0]   inflight;
  logic         err_orphan;

  int checks   = 0;
  int failures = 0;

  single_exp_sched #(.NREQ(4), .MAX_INFLIGHT(16)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .req_valid    (req_valid),
    .req_a        (req_a),
    .req_ready    (req_ready),
    .exp_in_valid (exp_in_valid),
    .exp_a        (exp_a),
    .exp_out_valid(exp_out_valid),
    .exp_c        (exp_c),
    .rsp_valid    (rsp_valid),
    .rsp_c        (rsp_c),
    .inflight     (inflight),
    .err_orphan   (err_orphan)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rstn = 1'b1;
    req_valid = '0;
    exp_out_valid = 1'b0;
    exp_c = '0;
    tick();
    tick();
    rstn = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b1;
    req_valid = 4'hF;
    req_a = {4{32'h3F800000}};
    exp_out_valid = 1'b1;
    exp_c = 32'h12345678;
    tick();
    tick();
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
    checks++; if (exp_in_valid !== 1'b0) begin failures++; $display("FAIL reset_exp_in_valid got %b exp 0", exp_in_valid); end
    checks++; if (exp_a !== 32'h0) begin failures++; $display("FAIL reset_exp_a got %h exp 0", exp_a); end
    checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL reset_rsp_valid got %b exp 0000", rsp_valid); end
    checks++; if (rsp_c !== 32'h0) begin failures++; $display("FAIL reset_rsp_c got %h exp 0", rsp_c); end
    checks++; if (inflight !== 5'd0) begin failures++; $display("FAIL reset_inflight got %0d exp 0", inflight); end
    checks++; if (err_orphan !== 1'b0) begin failures++; $display("FAIL reset_err_orphan got %b exp 0", err_orphan); end
    req_valid = '0;
    exp_out_valid = 1'b0;
    rstn = 1'b0;
  endtask

  task automatic test_single;
    do_reset();
    req_valid = 4'b0001;
    req_a = {32'h0, 32'h0, 32'h0, 32'h3F800000};
    #1;
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_req_ready got %b exp 0001", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (exp_in_valid !== 1'b1) begin failures++; $display("FAIL single_issue_valid got %b exp 1", exp_in_valid); end
    checks++; if (exp_a !== 32'h3F800000) begin failures++; $display("FAIL single_exp_a got %h exp 3f800000", exp_a); end
    checks++; if (inflight !== 5'd1) begin failures++; $display("FAIL single_inflight got %0d exp 1", inflight); end
    tick();
    checks++; if (exp_in_valid !== 1'b0) begin failures++; $display("FAIL single_issue_drop got %b exp 0", exp_in_valid); end
    checks++; if (exp_a !== 32'h3F800000) begin failures++; $display("FAIL single_exp_a_hold got %h exp 3f800000", exp_a); end
    exp_out_valid = 1'b1;
    exp_c = 32'h402DF854;
    tick();
    exp_out_valid = 1'b0;
    checks++; if (rsp_valid !== 4'b0001) begin failures++; $display("FAIL single_rsp_valid got %b exp 0001", rsp_valid); end
    checks++; if (rsp_c !== 32'h402DF854) begin failures++; $display("FAIL single_rsp_c got %h exp 402df854", rsp_c); end
    checks++; if (inflight !== 5'd0) begin failures++; $display("FAIL single_inflight_ret got %0d exp 0", inflight); end
    tick();
    checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL single_rsp_drop got %b exp 0000", rsp_valid); end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_oh;
    do_reset();
    req_valid = 4'hF;
    for (int i = 0; i < 4; i++) req_a[32*i +: 32] = 32'h10000000 + i;
    for (int k = 0; k < 8; k++) begin
      exp_oh = 4'b0001 << (k % 4);
      #1;
      checks++; if (req_ready !== exp_oh) begin failures++; $display("FAIL rr_grant[%0d] got %b exp %b", k, req_ready, exp_oh); end
      tick();
      checks++; if (exp_a !== 32'h10000000 + (k % 4)) begin failures++; $display("FAIL rr_exp_a[%0d] got %h exp %h", k, exp_a, 32'h10000000 + (k % 4)); end
    end
    req_valid = '0;
    checks++; if (inflight !== 5'd8) begin failures++; $display("FAIL rr_inflight got %0d exp 8", inflight); end
    exp_out_valid = 1'b1;
    for (int j = 0; j < 8; j++) begin
      exp_c = 32'hC0000000 + j;
      exp_oh = 4'b0001 << (j % 4);
      tick();
      checks++; if (rsp_valid !== exp_oh) begin failures++; $display("FAIL rr_rsp_valid[%0d] got %b exp %b", j, rsp_valid, exp_oh); end
      checks++; if (rsp_c !== 32'hC0000000 + j) begin failures++; $display("FAIL rr_rsp_c[%0d] got %h exp %h", j, rsp_c, 32'hC0000000 + j); end
    end
    exp_out_valid = 1'b0;
    tick();
    checks++; if (inflight !== 5'd0) begin failures++; $display("FAIL rr_drain_inflight got %0d exp 0", inflight); end
    checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL rr_drain_rsp got %b exp 0000", rsp_valid); end
  endtask

  task automatic test_full_and_stream;
    int q[$];
    int last;
    int g;
    int t;
    logic [3:0] exp_oh;
    do_reset();
    req_valid = 4'b0100;
    for (int i = 0; i < 16; i++) begin
      req_a[95:64] = 32'h20000000 + i;
      #1;
      checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL full_fill_grant[%0d] got %b exp 0100", i, req_ready); end
      q.push_back(2);
      tick();
    end
    last = 2;
    checks++; if (inflight !== 5'd16) begin failures++; $display("FAIL full_inflight got %0d exp 16", inflight); end
    #1;
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL full_blocked got %b exp 0000", req_ready); end
    tick();
    checks++; if (exp_in_valid !== 1'b0) begin failures++; $display("FAIL full_no_issue got %b exp 0", exp_in_valid); end
    req_valid = 4'hF;
    for (int i = 0; i < 4; i++) req_a[32*i +: 32] = 32'h30000000 + i;
    exp_out_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      exp_c = 32'hD0000000 + c;
      g = (last + 1) % 4;
      exp_oh = 4'b0001 << g;
      #1;
      checks++; if (req_ready !== exp_oh) begin failures++; $display("FAIL stream_grant[%0d] got %b exp %b", c, req_ready, exp_oh); end
      q.push_back(g);
      t = q.pop_front();
      last = g;
      tick();
      exp_oh = 4'b0001 << t;
      checks++; if (rsp_valid !== exp_oh) begin failures++; $display("FAIL stream_tag[%0d] got %b exp %b", c, rsp_valid, exp_oh); end
      checks++; if (rsp_c !== 32'hD0000000 + c) begin failures++; $display("FAIL stream_rsp_c[%0d] got %h exp %h", c, rsp_c, 32'hD0000000 + c); end
      checks++; if (inflight !== 5'd16) begin failures++; $display("FAIL stream_inflight[%0d] got %0d exp 16", c, inflight); end
      checks++; if (exp_in_valid !== 1'b1) begin failures++; $display("FAIL stream_issue[%0d] got %b exp 1", c, exp_in_valid); end
    end
    req_valid = '0;
    for (int c = 0; c < 16; c++) begin
      exp_c = 32'hE0000000 + c;
      t = q.pop_front();
      exp_oh = 4'b0001 << t;
      tick();
      checks++; if (rsp_valid !== exp_oh) begin failures++; $display("FAIL drain_tag[%0d] got %b exp %b", c, rsp_valid, exp_oh); end
    end
    exp_out_valid = 1'b0;
    tick();
    checks++; if (inflight !== 5'd0) begin failures++; $display("FAIL drain_inflight got %0d exp 0", inflight); end
    checks++; if (err_orphan !== 1'b0) begin failures++; $display("FAIL drain_no_orphan got %b exp 0", err_orphan); end
  endtask

  task automatic test_empty_bypass;
    do_reset();
    req_valid = 4'b0010;
    req_a = {32'h0, 32'h0, 32'h40000000, 32'h0};
    exp_out_valid = 1'b1;
    exp_c = 32'hABCD0001;
    #1;
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL bypass_grant got %b exp 0010", req_ready); end
    tick();
    req_valid = '0;
    exp_out_valid = 1'b0;
    checks++; if (rsp_valid !== 4'b0010) begin failures++; $display("FAIL bypass_rsp got %b exp 0010", rsp_valid); end
    checks++; if (inflight !== 5'd0) begin failures++; $display("FAIL bypass_inflight got %0d exp 0", inflight); end
    checks++; if (err_orphan !== 1'b0) begin failures++; $display("FAIL bypass_orphan got %b exp 0", err_orphan); end
  endtask

  task automatic test_orphan;
    do_reset();
    exp_out_valid = 1'b1;
    exp_c = 32'h55555555;
    tick();
    exp_out_valid = 1'b0;
    checks++; if (err_orphan !== 1'b1) begin failures++; $display("FAIL orphan_set got %b exp 1", err_orphan); end
    checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL orphan_rsp got %b exp 0000", rsp_valid); end
    checks++; if (inflight !== 5'd0) begin failures++; $display("FAIL orphan_inflight got %0d exp 0", inflight); end
    tick();
    tick();
    checks++; if (err_orphan !== 1'b1) begin failures++; $display("FAIL orphan_sticky got %b exp 1", err_orphan); end
    do_reset();
    checks++; if (err_orphan !== 1'b0) begin failures++; $display("FAIL orphan_cleared got %b exp 0", err_orphan); end
  endtask

  task automatic test_reset_midop;
    do_reset();
    req_valid = 4'hF;
    for (int i = 0; i < 4; i++) req_a[32*i +: 32] = 32'h50000000 + i;
    for (int k = 0; k < 5; k++) tick();
    checks++; if (inflight !== 5'd5) begin failures++; $display("FAIL midop_inflight got %0d exp 5", inflight); end
    rstn = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL midop_ready_in_reset got %b exp 0000", req_ready); end
    tick();
    checks++; if (exp_in_valid !== 1'b0) begin failures++; $display("FAIL midop_issue got %b exp 0", exp_in_valid); end
    checks++; if (exp_a !== 32'h0) begin failures++; $display("FAIL midop_exp_a got %h exp 0", exp_a); end
    checks++; if (inflight !== 5'd0) begin failures++; $display("FAIL midop_inflight_rst got %0d exp 0", inflight); end
    rstn = 1'b0;
    req_valid = '0;
    exp_out_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_c = 32'h60000000 + k;
      tick();
      checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL midop_late_rsp[%0d] got %b exp 0000", k, rsp_valid); end
    end
    exp_out_valid = 1'b0;
    checks++; if (err_orphan !== 1'b1) begin failures++; $display("FAIL midop_orphan got %b exp 1", err_orphan); end
    checks++; if (inflight !== 5'd0) begin failures++; $display("FAIL midop_inflight_late got %0d exp 0", inflight); end
  endtask

  initial begin
    rstn = 1'b1;
    req_valid = '0;
    req_a = '0;
    exp_out_valid = 1'b0;
    exp_c = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_full_and_stream();
    test_empty_bypass();
    test_orphan();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
